// File: rtl/pipe_ctrl_if.sv
// ID-stage control bundle interface between the decode datapath and pipe_ctrl_unit.
// master: drives the instruction fields and EX-stage hazard info, receives controls.
// slave : the control unit; receives instruction fields, drives the registered
//         ID/EX bundle, PC-mux selects, stall/clear controls, halted and perf counters.
interface pipe_ctrl_if #(
   parameter int unsigned OP_W   = 4,
   parameter int unsigned FUNC_W = 4,
   parameter int unsigned REG_AW = 4
);
   // ID-side inputs to the control unit
   logic              instr_valid;
   logic [OP_W-1:0]   op;
   logic [FUNC_W-1:0] func;
   logic [REG_AW-1:0] rs_a;
   logic [REG_AW-1:0] rs_b;
   logic [REG_AW-1:0] ex_rd;
   logic              ex_memR;
   logic              branch_taken;

   // Registered ID/EX bundle
   logic       ex_aluSrcA;
   logic       ex_aluSrcB;
   logic       ex_byteEN;
   logic       ex_memW;
   logic       ex_memR_o;
   logic       ex_R15w;
   logic       ex_regW;
   logic [2:0] ex_aluOP;
   logic [1:0] ex_WBsrc;

   // PC-mux selects and pipeline controls
   logic       brnch;
   logic       jmp;
   logic [1:0] brnchOP;
   logic       pc_stall;
   logic       if_id_stall;
   logic       if_id_clr;
   logic       halted;
   logic [15:0] stall_cnt;
   logic [15:0] flush_cnt;

   modport master (
      output instr_valid, op, func, rs_a, rs_b, ex_rd, ex_memR, branch_taken,
      input  ex_aluSrcA, ex_aluSrcB, ex_byteEN, ex_memW, ex_memR_o, ex_R15w, ex_regW,
      input  ex_aluOP, ex_WBsrc, brnch, jmp, brnchOP,
      input  pc_stall, if_id_stall, if_id_clr, halted, stall_cnt, flush_cnt
   );

   modport slave (
      input  instr_valid, op, func, rs_a, rs_b, ex_rd, ex_memR, branch_taken,
      output ex_aluSrcA, ex_aluSrcB, ex_byteEN, ex_memW, ex_memR_o, ex_R15w, ex_regW,
      output ex_aluOP, ex_WBsrc, brnch, jmp, brnchOP,
      output pc_stall, if_id_stall, if_id_clr, halted, stall_cnt, flush_cnt
   );
endinterface

// File: rtl/pipe_ctrl_unit.sv
// Stateful ID-stage control unit: decodes the instruction in IF/ID, registers the
// control bundle into ID/EX, and generates stalls, bubbles and flushes for load-use
// hazards, multi-cycle MUL/DIV, taken branch/jump and the HLT drain/lock sequence.
// Ports: clk, rst (async, active-high), bus (pipe_ctrl_if.slave) carrying the
// instruction fields, EX hazard info, ex_* bundle, brnch/jmp/brnchOP,
// pc_stall/if_id_stall/if_id_clr, halted and the stall/flush counters.
// Optional: define PIPE_CTRL_PERF_CNT_EN to build saturating stall/flush counters;
// otherwise both counter ports read 0.
module pipe_ctrl_unit #(
   parameter int unsigned OP_W         = 4,
   parameter int unsigned FUNC_W       = 4,
   parameter int unsigned REG_AW       = 4,
   parameter int unsigned MULDIV_LAT   = 4,
   parameter int unsigned FLUSH_CYCLES = 1,
   parameter int unsigned DRAIN_CYCLES = 3
) (
   input logic        clk,
   input logic        rst,
   pipe_ctrl_if.slave bus
);
   localparam int unsigned SEQ_W = 16;

   typedef enum logic [1:0] {RUN = 2'd0, MULDIV = 2'd1, DRAIN = 2'd2, HALTED = 2'd3} state_t;

   typedef struct packed {
      logic       alusrca;
      logic       alusrcb;
      logic       byteen;
      logic       memw;
      logic       memr;
      logic       r15w;
      logic       regw;
      logic [2:0] aluop;
      logic [1:0] wbsrc;
   } ctrl_t;

   state_t             state_q, state_d;
   logic [SEQ_W-1:0]   seq_q, seq_d;
   logic [SEQ_W-1:0]   flush_q, flush_d;
   ctrl_t              bundle_q, bundle_d;

   logic [OP_W-1:0]    op_l;
   logic [FUNC_W-1:0]  func_l;
   logic [3:0]         opc, fnc;

   ctrl_t              dec;
   logic               dec_brnch, dec_jmp, dec_hlt, dec_md;
   logic [1:0]         dec_bop;

   logic               dec_ok, load_use;
   logic               pc_stall_c, if_id_stall_c, if_id_clr_c, brnch_c, jmp_c;
   logic [1:0]         brnchop_c;

   assign op_l   = bus.op;
   assign func_l = bus.func;
   assign opc    = 4'(op_l);
   assign fnc    = 4'(func_l);

   // Instruction decode table
   always_comb begin
      dec       = '0;
      dec_brnch = 1'b0;
      dec_jmp   = 1'b0;
      dec_hlt   = 1'b0;
      dec_md    = 1'b0;
      dec_bop   = 2'b00;
      case (opc)
         4'b1111: begin
            dec_md    = (fnc == 4'b0100) || (fnc == 4'b0101);
            dec.r15w  = dec_md;
            dec.aluop = 3'b000;
            dec.wbsrc = 2'b10;
            dec.regw  = 1'b1;
         end
         4'b1000, 4'b1001: begin
            dec.alusrcb = 1'b1;
            dec.aluop   = (opc == 4'b1000) ? 3'b010 : 3'b011;
            dec.wbsrc   = 2'b10;
            dec.regw    = 1'b1;
         end
         4'b1010, 4'b1011, 4'b1100, 4'b1101: begin
            // Memory ops share address generation; opc[0] selects store, opc[2] word size
            dec.alusrca = 1'b1;
            dec.alusrcb = 1'b1;
            dec.aluop   = 3'b100;
            dec.byteen  = ~opc[2];
            dec.memw    = opc[0];
            dec.memr    = ~opc[0];
            dec.regw    = ~opc[0];
            dec.wbsrc   = (opc == 4'b1100) ? 2'b00 : 2'b01;
         end
         4'b0101: begin dec_brnch = 1'b1; dec_bop = 2'b00; end
         4'b0100: begin dec_brnch = 1'b1; dec_bop = 2'b11; end
         4'b0110: begin dec_brnch = 1'b1; dec_bop = 2'b01; end
         4'b0001: dec_jmp = 1'b1;
         4'b0000: dec_hlt = 1'b1;
         default: ;
      endcase
   end

   // Wrong-path instructions behind a taken branch/jump decode as NOP
   assign dec_ok   = bus.instr_valid && (flush_q == '0);
   assign load_use = dec_ok && bus.ex_memR && (bus.ex_rd != '0) &&
                     ((bus.ex_rd == bus.rs_a) || (bus.ex_rd == bus.rs_b));

   // Next-state and control generation
   always_comb begin
      state_d       = state_q;
      seq_d         = seq_q;
      flush_d       = (flush_q != '0) ? flush_q - SEQ_W'(1) : '0;
      bundle_d      = '0;
      pc_stall_c    = 1'b0;
      if_id_stall_c = 1'b0;
      if_id_clr_c   = (flush_q != '0);
      brnch_c       = 1'b0;
      jmp_c         = 1'b0;
      brnchop_c     = 2'b00;
      case (state_q)
         HALTED: pc_stall_c = 1'b1;
         MULDIV: begin
            pc_stall_c    = 1'b1;
            if_id_stall_c = 1'b1;
            if (seq_q == '0) state_d = RUN;
            else             seq_d   = seq_q - SEQ_W'(1);
         end
         DRAIN: begin
            pc_stall_c  = 1'b1;
            if_id_clr_c = 1'b1;
            if (seq_q == '0) state_d = HALTED;
            else             seq_d   = seq_q - SEQ_W'(1);
         end
         default: begin
            if (dec_ok && dec_hlt) begin
               pc_stall_c  = 1'b1;
               if_id_clr_c = 1'b1;
               if (DRAIN_CYCLES == 0) begin
                  state_d = HALTED;
               end else begin
                  state_d = DRAIN;
                  seq_d   = SEQ_W'(DRAIN_CYCLES - 1);
               end
            end else if (load_use) begin
               pc_stall_c    = 1'b1;
               if_id_stall_c = 1'b1;
            end else if (dec_ok) begin
               bundle_d  = dec;
               brnch_c   = dec_brnch;
               jmp_c     = dec_jmp;
               brnchop_c = dec_bop;
               if (dec_jmp || (dec_brnch && bus.branch_taken)) begin
                  if_id_clr_c = 1'b1;
                  flush_d     = SEQ_W'(FLUSH_CYCLES - 1);
               end
               if (dec_md && (MULDIV_LAT > 1)) begin
                  state_d = MULDIV;
                  seq_d   = SEQ_W'(MULDIV_LAT - 2);
               end
            end
         end
      endcase
   end

   // State, sequence counters and ID/EX bundle registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= RUN;
         seq_q    <= '0;
         flush_q  <= '0;
         bundle_q <= '0;
      end else begin
         state_q  <= state_d;
         seq_q    <= seq_d;
         flush_q  <= flush_d;
         bundle_q <= bundle_d;
      end
   end

   assign bus.ex_aluSrcA  = bundle_q.alusrca;
   assign bus.ex_aluSrcB  = bundle_q.alusrcb;
   assign bus.ex_byteEN   = bundle_q.byteen;
   assign bus.ex_memW     = bundle_q.memw;
   assign bus.ex_memR_o   = bundle_q.memr;
   assign bus.ex_R15w     = bundle_q.r15w;
   assign bus.ex_regW     = bundle_q.regw;
   assign bus.ex_aluOP    = bundle_q.aluop;
   assign bus.ex_WBsrc    = bundle_q.wbsrc;
   assign bus.halted      = (state_q == HALTED);

   // Combinational controls are forced quiet while reset is held
   assign bus.pc_stall    = pc_stall_c & ~rst;
   assign bus.if_id_stall = if_id_stall_c & ~rst;
   assign bus.if_id_clr   = if_id_clr_c & ~rst;
   assign bus.brnch       = brnch_c & ~rst;
   assign bus.jmp         = jmp_c & ~rst;
   assign bus.brnchOP     = rst ? 2'b00 : brnchop_c;

`ifdef PIPE_CTRL_PERF_CNT_EN
   localparam int unsigned CNT_W = 16;
   logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;

   // Saturating performance counters
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         if (pc_stall_c && (state_q != HALTED) && (stall_cnt_q != '1))
            stall_cnt_q <= stall_cnt_q + CNT_W'(1);
         if (if_id_clr_c && (flush_cnt_q != '1))
            flush_cnt_q <= flush_cnt_q + CNT_W'(1);
      end
   end

   assign bus.stall_cnt = stall_cnt_q;
   assign bus.flush_cnt = flush_cnt_q;
`else
   assign bus.stall_cnt = '0;
   assign bus.flush_cnt = '0;
`endif
endmodule

// File: doc/pipe_ctrl_unit.md
Name: pipe_ctrl_unit

Overview:
- Parametrised, stateful successor to the pipeline's combinational decoder.
- Sits in ID and registers the decoded control bundle into the ID/EX boundary.
- Owns stall, bubble and flush generation: load-use hazards, multi-cycle MUL/DIV, taken branch/jump flush, and a halt drain/lock sequence.

Parameters:
OP_W, 4, opcode width
FUNC_W, 4, R-type function-code width
REG_AW, 4, register-address width for hazard compare
MULDIV_LAT, 4, total EX cycles for MUL/DIV (min 1)
FLUSH_CYCLES, 1, cycles if_id_clr held after taken branch/jump (min 1)
DRAIN_CYCLES, 3, bubbles inserted after HLT before locking

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-high reset
instr_valid  in  1  IF/ID holds a real instruction
op  in  OP_W  opcode
func  in  FUNC_W  R-type function code
rs_a, rs_b  in  REG_AW  ID source registers
ex_rd  in  REG_AW  destination register of instruction now in EX
ex_memR  in  1  instruction in EX is a load
branch_taken  in  1  ID branch comparator result
ex_aluSrcA, ex_aluSrcB, ex_byteEN, ex_memW, ex_memR_o, ex_R15w, ex_regW  out  1  registered bundle
ex_aluOP  out  3  registered ALU op
ex_WBsrc  out  2  registered write-back select
brnch, jmp  out  1  ID PC-mux selects (combinational, gated)
brnchOP  out  2  branch compare select (combinational)
pc_stall, if_id_stall, if_id_clr  out  1  pipeline controls
halted  out  1  processor halted
stall_cnt, flush_cnt  out  16  performance counters (see Optional Feature)

Behaviour:
- Decode table, low OP_W bits:
  - 1111 R-type: aluOP 000, WBsrc 10, regW 1. R15w=1 iff func is 0100 or 0101 (MUL/DIV).
  - 1000 ANDi: srcB 1, aluOP 010, WBsrc 10, regW 1.
  - 1001 ORi: as ANDi, aluOP 011.
  - 1010 LBU: srcA 1, srcB 1, aluOP 100, byteEN 1, memR 1, WBsrc 01, regW 1.
  - 1011 SB: as LBU but memW 1, memR 0, regW 0.
  - 1100 LW: as LBU, byteEN 0, WBsrc 00.
  - 1101 SW: as SB, byteEN 0.
  - 0101 BLT / 0100 BGT / 0110 BEQ: brnch 1, brnchOP 00 / 11 / 01.
  - 0001 JMP: jmp 1.
  - 0000 HLT.
  - All others: NOP.
- No X outputs: every field not listed is 0.
- Reset: FSM=RUN, all counters 0, every registered output 0, halted 0. Combinational outputs are 0 while rst is high.
- Latency: bundle appears on ex_* one clk after decode. A bubble registers all-zero.
- FSM states RUN, MULDIV, DRAIN, HALTED. Priority, highest first: rst, HALTED, MULDIV/DRAIN, HLT decode, load-use, branch/jump.
- RUN transitions:
  - Valid HLT: if_id_clr=1, pc_stall=1, bubble, go DRAIN with count DRAIN_CYCLES-1.
  - Valid MUL/DIV with MULDIV_LAT>1: bundle registered normally, go MULDIV with count MULDIV_LAT-2.
- MULDIV: pc_stall=if_id_stall=1, bubble each cycle. Exit to RUN when count=0, else decrement.
- DRAIN: pc_stall=1, if_id_clr=1, bubble. Exit to HALTED when count=0.
- HALTED: halted=1, pc_stall=1, bubble forever. Only rst leaves.
- Load-use, in RUN: condition is instr_valid & ex_memR & ex_rd!=0 & (ex_rd==rs_a | ex_rd==rs_b).
  - Response: pc_stall=if_id_stall=1, bubble, brnch=jmp=0 this cycle.
  - The instruction re-decodes next cycle.
- Branch/jump, in RUN, no stall: jmp=1, or brnch=1 with branch_taken.
  - Load flush counter with FLUSH_CYCLES. if_id_clr=1 while counter nonzero, starting the same cycle.
  - A new taken branch reloads the counter.
  - Any decode occurring while if_id_clr is asserted is treated as a NOP.
- instr_valid=0 decodes as NOP, with no hazard check.
- rst mid-MULDIV/DRAIN/HALTED: immediate return to reset state.

Optional Feature:
- Macro: PIPE_CTRL_PERF_CNT_EN.
- Defined:
  - stall_cnt increments each cycle pc_stall=1 and halted=0.
  - flush_cnt increments each cycle if_id_clr=1.
  - Both saturate at 16'hFFFF and clear on rst.
- Undefined: no counter logic; both ports tied to 0.

Test Plan:
- Reset: rst=1 mid-stream, release -> all ex_* 0, halted 0, pc_stall 0. ANDi (op 1000) next cycle -> ex_aluOP=010, ex_aluSrcB=1, ex_regW=1 one clk later.
- Load-use: EX has LW with ex_rd=5, ex_memR=1; ID has ADD with rs_a=5 -> pc_stall=if_id_stall=1 for exactly 1 cycle, ex_* zero that cycle. ADD bundle issues the following cycle. Repeat with ex_rd=0 -> no stall.
- MUL, MULDIV_LAT=4: op 1111, func 0100 -> ex_R15w=1 next clk, then 3 cycles of stall with bubbles, then RUN.
- Branch: BEQ, branch_taken=1, FLUSH_CYCLES=2 -> brnchOP=01, brnch=1, if_id_clr high for 2 cycles. Same BEQ with concurrent load-use -> brnch=0, stall first, branch taken next cycle.
- HLT, DRAIN_CYCLES=3 -> 3 bubble cycles with if_id_clr=1, then halted=1 held. Subsequent ops ignored until rst; rst clears halted.
- With PIPE_CTRL_PERF_CNT_EN: preceding load-use + MUL sequence -> stall_cnt=4. Without the macro -> stall_cnt=0.
